// File: rtl/if_id_buffer.sv
// IF/ID skid buffer: two-entry {Inst, PC} FIFO between fetch and decode.
// Head entry is pre-decoded into MIPS-style fields for the next stage.
module if_id_buffer #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] Inst,
    input  logic [31:0] PC,
    input  logic        Flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [31:0] imm_sext,
    output logic [31:0] jaddr,
    output logic [1:0]  count
);

    logic [31:0] inst_q [DEPTH];
    logic [31:0] pc_q   [DEPTH];
    logic        wptr_q, wptr_d;
    logic        rptr_q, rptr_d;
    logic [1:0]  count_q, count_d;
    logic        push, pop;

    assign in_ready  = (count_q < 2'(DEPTH));
    assign out_valid = (count_q != 2'd0);
    assign count     = count_q;

    assign push = in_valid & in_ready & ~Flush & ~Reset;
    assign pop  = out_valid & out_ready & ~Flush & ~Reset;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = ~wptr_q;
        if (pop)  rptr_d = ~rptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Reset outranks Flush, which outranks normal push/pop.
    always_ff @(posedge Clk) begin
        if (Reset || Flush) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            inst_q[wptr_q] <= Inst;
            pc_q[wptr_q]   <= PC;
        end
    end

    // Storage is masked whenever empty so stale entries never leak out.
    assign out_inst = out_valid ? inst_q[rptr_q] : NOP_INST;
    assign out_pc   = out_valid ? pc_q[rptr_q]   : 32'd0;
    assign out_pc4  = out_pc + 32'd4;

    assign opcode   = out_inst[31:26];
    assign rs       = out_inst[25:21];
    assign rt       = out_inst[20:16];
    assign rd       = out_inst[15:11];
    assign shamt    = out_inst[10:6];
    assign funct    = out_inst[5:0];
    assign imm_sext = {{16{out_inst[15]}}, out_inst[15:0]};
    assign jaddr    = {out_pc4[31:28], out_inst[25:0], 2'b00};

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: reset, ordering, full/empty,
// streaming, flush, reset priority and decode fields.
module tb_if_id_buffer;

    logic        Clk = 1'b0;
    logic        Reset, in_valid, in_ready, Flush, out_valid, out_ready;
    logic [31:0] Inst, PC, out_inst, out_pc, out_pc4, imm_sext, jaddr;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [1:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    if_id_buffer dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .Inst(Inst), .PC(PC), .Flush(Flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_pc4(out_pc4), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .funct(funct), .imm_sext(imm_sext), .jaddr(jaddr),
        .count(count)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1; Flush = 0; in_valid = 0; out_ready = 0;
        Inst = 32'hDEAD_BEEF; PC = 32'h1234_5678;
        step(); step();
        Reset = 0;
        n_checks++;
        if (count !== 2'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", count); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        n_checks++;
        if (out_inst !== 32'h0) begin n_fail++; $display("FAIL rst_out_inst got %h want 0", out_inst); end
        n_checks++;
        if (out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_out_pc got %h want 0", out_pc); end
        n_checks++;
        if (out_pc4 !== 32'h4) begin n_fail++; $display("FAIL rst_out_pc4 got %h want 4", out_pc4); end
    endtask

    task automatic test_single();
        in_valid = 1; Inst = 32'h2008_0005; PC = 32'h0; out_ready = 1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass got %b want 0", out_valid); end
        step();
        in_valid = 0;
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
        n_checks++;
        if (rt !== 5'd8) begin n_fail++; $display("FAIL single_rt got %0d want 8", rt); end
        n_checks++;
        if (opcode !== 6'h08) begin n_fail++; $display("FAIL single_opcode got %h want 08", opcode); end
        n_checks++;
        if (imm_sext !== 32'h5) begin n_fail++; $display("FAIL single_imm got %h want 5", imm_sext); end
        n_checks++;
        if (out_pc4 !== 32'h4) begin n_fail++; $display("FAIL single_pc4 got %h want 4", out_pc4); end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid got %b want 0", out_valid); end
        n_checks++;
        if (out_inst !== 32'h0) begin n_fail++; $display("FAIL single_pop_inst got %h want 0", out_inst); end
    endtask

    task automatic test_full();
        out_ready = 0; in_valid = 1;
        Inst = 32'h00A4_1940; PC = 32'h10; step();
        Inst = 32'h1111_1111; PC = 32'h14; step();
        n_checks++;
        if (count !== 2'd2) begin n_fail++; $display("FAIL full_count got %0d want 2", count); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        Inst = 32'h2222_2222; PC = 32'h18; step();
        in_valid = 0;
        n_checks++;
        if (count !== 2'd2) begin n_fail++; $display("FAIL full_third_count got %0d want 2", count); end
        n_checks++;
        if (out_pc !== 32'h10) begin n_fail++; $display("FAIL full_hold_pc got %h want 10", out_pc); end
        n_checks++;
        if ({rs, rt, rd, shamt, funct} !== {5'd5, 5'd4, 5'd3, 5'd5, 6'd0})
            begin n_fail++; $display("FAIL full_fields got %h/%h/%h/%h/%h want 5/4/3/5/0", rs, rt, rd, shamt, funct); end
        n_checks++;
        if (imm_sext !== 32'h0000_1940) begin n_fail++; $display("FAIL full_imm got %h want 00001940", imm_sext); end
        out_ready = 1; step();
        n_checks++;
        if (out_pc !== 32'h14) begin n_fail++; $display("FAIL full_order1 got %h want 14", out_pc); end
        n_checks++;
        if (out_inst !== 32'h1111_1111) begin n_fail++; $display("FAIL full_order1_inst got %h want 11111111", out_inst); end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 0; in_valid = 1; Inst = 32'h0; PC = 32'h100; step();
        out_ready = 1;
        for (int i = 1; i <= 6; i++) begin
            PC = 32'h100 + 32'(4 * i);
            Inst = 32'hA000_0000 + 32'(i);
            step();
            n_checks++;
            if (count !== 2'd1) begin n_fail++; $display("FAIL b2b_count[%0d] got %0d want 1", i, count); end
            n_checks++;
            if (out_pc !== 32'h100 + 32'(4 * i))
                begin n_fail++; $display("FAIL b2b_pc[%0d] got %h want %h", i, out_pc, 32'h100 + 32'(4 * i)); end
        end
        in_valid = 0; step();
        n_checks++;
        if (count !== 2'd0) begin n_fail++; $display("FAIL b2b_drain got %0d want 0", count); end
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1;
        PC = 32'h200; Inst = 32'h1; step();
        PC = 32'h204; Inst = 32'h2; step();
        n_checks++;
        if (count !== 2'd2) begin n_fail++; $display("FAIL flush_pre_count got %0d want 2", count); end
        Flush = 1; PC = 32'h208; Inst = 32'h3; out_ready = 1; step();
        Flush = 0; in_valid = 0; out_ready = 0;
        n_checks++;
        if (count !== 2'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", count); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
        n_checks++;
        if (out_pc !== 32'h0) begin n_fail++; $display("FAIL flush_pc got %h want 0", out_pc); end
        in_valid = 1; PC = 32'h20C; Inst = 32'h4; step();
        in_valid = 0;
        n_checks++;
        if (out_pc !== 32'h20C) begin n_fail++; $display("FAIL flush_next_head got %h want 20c", out_pc); end
        n_checks++;
        if (count !== 2'd1) begin n_fail++; $display("FAIL flush_next_count got %0d want 1", count); end
        out_ready = 1; step();
        out_ready = 0;
    endtask

    task automatic test_reset_priority();
        out_ready = 0; in_valid = 1;
        PC = 32'h300; Inst = 32'h5; step();
        PC = 32'h304; Inst = 32'h6; step();
        Reset = 1; Flush = 1; out_ready = 1; PC = 32'h308; step();
        Reset = 0; Flush = 0; in_valid = 0; out_ready = 0;
        n_checks++;
        if (count !== 2'd0) begin n_fail++; $display("FAIL rstp_count got %0d want 0", count); end
        n_checks++;
        if (out_pc !== 32'h0) begin n_fail++; $display("FAIL rstp_pc got %h want 0", out_pc); end
        in_valid = 1; Inst = 32'h8C01_FFFC; PC = 32'hFFFF_FFFC; step();
        Inst = 32'h0800_0010; PC = 32'h3000_0000; step();
        in_valid = 0;
        n_checks++;
        if (out_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rstp_head got %h want fffffffc", out_pc); end
        n_checks++;
        if (imm_sext !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL sext_neg got %h want fffffffc", imm_sext); end
        n_checks++;
        if (out_pc4 !== 32'h0) begin n_fail++; $display("FAIL pc4_wrap got %h want 0", out_pc4); end
        n_checks++;
        if ({opcode, rs, rt} !== {6'h23, 5'd0, 5'd1})
            begin n_fail++; $display("FAIL lw_fields got %h/%h/%h want 23/0/1", opcode, rs, rt); end
        n_checks++;
        if (jaddr !== 32'h0007_FFF0) begin n_fail++; $display("FAIL jaddr_wrap got %h want 0007fff0", jaddr); end
        out_ready = 1; step();
        out_ready = 0;
        n_checks++;
        if (jaddr !== 32'h3000_0040) begin n_fail++; $display("FAIL jaddr_hi got %h want 30000040", jaddr); end
        n_checks++;
        if (out_pc4 !== 32'h3000_0004) begin n_fail++; $display("FAIL pc4_hi got %h want 30000004", out_pc4); end
    endtask

    initial begin
        Reset = 1; Flush = 0; in_valid = 0; out_ready = 0;
        Inst = 32'h0; PC = 32'h0;
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_flush();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 The block SHALL have parameter NOP_INST, default 32'h0000_0000, the instruction presented when no entry is valid.
REQ-002 The block SHALL have parameter DEPTH, default 2, the entry count; only DEPTH=2 is supported.
REQ-003 The block SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-004 Clk  input  1  rising-edge clock for all state.
REQ-005 Reset  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  fetch stage presents a valid Inst/PC pair.
REQ-007 in_ready  output  1  buffer can accept an entry this cycle.
REQ-008 Inst  input  32  fetched instruction.
REQ-009 PC  input  32  address of Inst.
REQ-010 Flush  input  1  discard all buffered entries (taken branch/jump).
REQ-011 out_valid  output  1  head entry valid toward decode/execute.
REQ-012 out_ready  input  1  consumer takes the head entry this cycle.
REQ-013 out_inst  output  32  head instruction.
REQ-014 out_pc  output  32  head PC.
REQ-015 out_pc4  output  32  head PC + 4.
REQ-016 opcode  output  6  out_inst[31:26].
REQ-017 rs, rt, rd  output  5 each  out_inst[25:21], [20:16], [15:11].
REQ-018 shamt, funct  output  5, 6  out_inst[10:6], [5:0].
REQ-019 imm_sext  output  32  out_inst[15:0] sign-extended.
REQ-020 jaddr  output  32  {out_pc4[31:28], out_inst[25:0], 2'b00}.
REQ-021 count  output  2  number of valid entries, 0..2.

Function
REQ-022 The buffer SHALL be a 2-entry FIFO of {Inst, PC} with a write pointer and read pointer, each 1 bit, wrapping 1->0.
REQ-023 in_ready SHALL equal (count < 2) and depend only on registered state, never combinationally on out_ready.
REQ-024 An entry SHALL be written at a rising edge when in_valid & in_ready & ~Flush & ~Reset.
REQ-025 An entry SHALL be popped at a rising edge when out_valid & out_ready & ~Flush & ~Reset.
REQ-026 Push and pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-027 count SHALL never exceed 2 or go below 0; push at count 2 is impossible since in_ready=0, and pop at count 0 is impossible since out_valid=0.
REQ-028 out_valid SHALL equal (count != 0).
REQ-029 Latency: an entry pushed at edge k into an empty buffer SHALL appear on out_* during the cycle after edge k, with no same-cycle bypass.
REQ-030 Entries SHALL leave in push order.
REQ-031 When out_valid=0, out_inst SHALL equal NOP_INST, out_pc SHALL equal 0, and all decode outputs SHALL derive from these values (out_pc4=4).
REQ-032 out_pc4 SHALL be out_pc + 32'd4 modulo 2^32; 32'hFFFF_FFFC SHALL give 0.
REQ-033 imm_sext SHALL replicate out_inst[15] into bits [31:16].
REQ-034 Flush SHALL set count=0 and both pointers=0 at the next edge, discarding any same-cycle push or pop; out_valid SHALL be 0 the following cycle.
REQ-035 Outputs held while out_valid=1 and out_ready=0 SHALL remain stable until popped or flushed.
REQ-036 Entry storage SHALL only be written on a push; stale storage SHALL never reach out_* while out_valid=0.

Reset
REQ-037 Reset SHALL dominate Flush, push and pop.
REQ-038 At the edge where Reset=1, the block SHALL set count=0, both pointers=0, out_valid=0, in_ready=1, out_inst=NOP_INST, out_pc=0.
REQ-039 A Reset asserted mid-stream SHALL discard all entries, and the first push after Reset deasserts SHALL become head.
REQ-040 Entry storage contents SHALL need no reset.

Verification
REQ-041 Reset, then push Inst=32'h2008_0005/PC=0 with out_ready=1 -> next cycle out_valid=1, rt=8, imm_sext=5, out_pc4=4; following cycle out_valid=0, out_inst=0.
REQ-042 out_ready=0; push PC=0x10, 0x14; try 0x18 -> count=2, in_ready=0, third not accepted; out_ready=1 -> outputs 0x10 then 0x14 in order.
REQ-043 count=1 with continuous push and pop for 6 cycles -> count stays 1, pointers wrap, and PCs emerge in order one per cycle.
REQ-044 count=2 with Flush=1 plus in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1, and the pushed entry is absent.
REQ-045 Reset=1 together with Flush, push and pop at count=2 -> count=0, out_pc=0; Inst=32'h8C01_FFFC -> imm_sext=32'hFFFF_FFFC; PC=32'hFFFF_FFFC -> out_pc4=0.
